onchip_memory_arbiter: RTL and testbench

- Two-requester Avalon-MM arbiter in front of the single-port on-chip memory: 32-bit data, 16-bit word address, 51200 words, 1-cycle read latency.
- Lets a CPU data master (m0) and a DMA/accelerator master (m1) share the RAM with round-robin fairness and fixed-latency read return.
- Drops out-of-range accesses and logs the first offending address.

---
 rtl/onchip_memory_arbiter_if.sv | 38 +++
 rtl/onchip_memory_arbiter.sv | 130 +++++++++++++
 tb/tb_onchip_memory_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_memory_arbiter_if.sv
// Avalon-MM command/response bundle between one master and the arbiter.
// The arbiter takes the slave side; the requester takes the master side.
interface onchip_memory_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address,
    output byteenable,
    output read,
    output write,
    output writedata,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  byteenable,
    input  read,
    input  write,
    input  writedata,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// Round-robin two-master arbiter in front of a 1-cycle on-chip RAM.
// Out-of-range and read+write accesses are absorbed and logged.
module onchip_memory_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int MEM_WORDS = 51200
) (
  input  logic              clk,
  input  logic              reset_n,
  onchip_memory_arbiter_if.slave m0,
  onchip_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clear
);

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(MEM_WORDS);

  logic              prio_q, prio_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic              rd_oor_q, rd_oor_d;
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              req0, req1;
  logic              gnt0, gnt1, gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wd;
  logic              sel_rd, sel_wr;
  logic              in_range;
  logic              acc_rd, err_ev;
  logic              vld0, vld1;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    req0 = m0.read | m0.write;
    req1 = m1.read | m1.write;
    gnt0 = req0 & (~req1 | ~prio_q);
    gnt1 = req1 & (~req0 | prio_q);
    gnt  = gnt0 | gnt1;

    sel_addr = gnt1 ? m1.address    : m0.address;
    sel_be   = gnt1 ? m1.byteenable : m0.byteenable;
    sel_wd   = gnt1 ? m1.writedata  : m0.writedata;
    sel_rd   = gnt1 ? m1.read       : m0.read;
    sel_wr   = gnt1 ? m1.write      : m0.write;

    in_range = {1'b0, sel_addr} < LIMIT;
    // read+write together is handled as a write
    acc_rd   = gnt & sel_rd & ~sel_wr;
    err_ev   = gnt & (~in_range | (sel_rd & sel_wr));
  end

  always_comb begin
    prio_d     = prio_q;
    rd_pend_d  = acc_rd;
    rd_owner_d = rd_owner_q;
    rd_oor_d   = rd_oor_q;
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;

    if (gnt) begin
      prio_d = gnt0;
    end
    if (acc_rd) begin
      rd_owner_d = gnt1;
      rd_oor_d   = ~in_range;
    end
    if (err_clear) begin
      err_flag_d = 1'b0;
      err_addr_d = '0;
    end else if (err_ev & ~err_flag_q) begin
      err_flag_d = 1'b1;
      err_addr_d = sel_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      prio_q     <= prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    vld0  = reset_n & rd_pend_q & ~rd_owner_q;
    vld1  = reset_n & rd_pend_q & rd_owner_q;
    rdata = rd_oor_q ? '0 : mem_readdata;

    m0.waitrequest   = ~reset_n | (req0 & ~gnt0);
    m1.waitrequest   = ~reset_n | (req1 & ~gnt1);
    m0.readdatavalid = vld0;
    m1.readdatavalid = vld1;
    m0.readdata      = vld0 ? rdata : '0;
    m1.readdata      = vld1 ? rdata : '0;

    mem_address    = sel_addr;
    mem_byteenable = sel_be;
    mem_writedata  = sel_wd;
    mem_chipselect = reset_n & gnt & in_range;
    mem_write      = reset_n & gnt & in_range & sel_wr;
    mem_clken      = reset_n;
  end

  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: directed scenarios plus random
// traffic against a word-level model of arbitration and memory.
module tb_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        err_clear = 1'b0;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic        err_flag;
  logic [15:0] err_addr;

  onchip_memory_arbiter_if m0_if();
  onchip_memory_arbiter_if m1_if();

  onchip_memory_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .err_flag       (err_flag),
    .err_addr       (err_addr),
    .err_clear      (err_clear)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    return 32'(a) * 32'h9E3779B9 + 32'h1234;
  endfunction

  // RAM stand-in: registered read, byte-lane writes
  logic [31:0] ram [int];
  logic [31:0] ram_w;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      ram_w = ram.exists(int'(mem_address)) ?
        ram[int'(mem_address)] : init_val(int'(mem_address));
      mem_readdata <= ram_w;
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram_w[8*b +: 8] = mem_writedata[8*b +: 8];
        ram[int'(mem_address)] = ram_w;
      end
    end
  end

  // reference model state
  logic [31:0] ref_mem [int];
  int          m_prio = 0;
  bit          m_pv = 0;
  int          m_po = 0;
  logic [31:0] m_pd = '0;
  bit          m_ef = 0;
  logic [15:0] m_ea = '0;

  // expectations for the current cycle
  int          e_g;
  bit          e_w0, e_w1, e_v0, e_v1;
  bit          e_cs, e_mw, e_inr, e_ef;
  bit          e_grd, e_gwr;
  logic [15:0] e_ga, e_ea;
  logic [3:0]  e_gbe;
  logic [31:0] e_gwd, e_d;

  int total = 0;
  int bad = 0;

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ?
      ref_mem[int'(a)] : init_val(int'(a));
  endfunction

  task automatic cmd(input int m, input bit rd, input bit wr,
                     input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  task automatic idle();
    cmd(0, 0, 0, '0, '0, '0);
    cmd(1, 0, 0, '0, '0, '0);
  endtask

  task automatic eval();
    bit r0, r1;
    @(negedge clk);
    e_d = m_pd;
    if (!reset_n) begin
      m_prio = 0; m_pv = 0; m_ef = 0; m_ea = '0;
      e_g = -1; e_w0 = 1; e_w1 = 1; e_v0 = 0; e_v1 = 0;
      e_cs = 0; e_mw = 0; e_ef = 0; e_ea = '0;
      e_grd = 0; e_gwr = 0; e_inr = 1;
    end else begin
      r0 = m0_if.read | m0_if.write;
      r1 = m1_if.read | m1_if.write;
      if (r0 && r1) e_g = m_prio;
      else if (r0) e_g = 0;
      else if (r1) e_g = 1;
      else e_g = -1;
      e_w0 = r0 && e_g != 0;
      e_w1 = r1 && e_g != 1;
      e_v0 = m_pv && m_po == 0;
      e_v1 = m_pv && m_po == 1;
      e_ga  = (e_g == 1) ? m1_if.address : m0_if.address;
      e_gbe = (e_g == 1) ? m1_if.byteenable : m0_if.byteenable;
      e_gwd = (e_g == 1) ? m1_if.writedata : m0_if.writedata;
      e_grd = (e_g == 1) ? m1_if.read : m0_if.read;
      e_gwr = (e_g == 1) ? m1_if.write : m0_if.write;
      e_inr = e_ga < 16'd51200;
      e_cs = e_g >= 0 && e_inr;
      e_mw = e_cs && e_gwr;
      e_ef = m_ef;
      e_ea = m_ea;
    end
  endtask

  task automatic advance();
    bit hit;
    logic [31:0] w;
    if (reset_n) begin
      hit = e_g >= 0;
      m_pv = hit && e_grd && !e_gwr;
      if (m_pv) begin
        m_po = e_g;
        m_pd = e_inr ? ref_word(e_ga) : '0;
      end
      if (hit && e_gwr && e_inr) begin
        w = ref_word(e_ga);
        for (int b = 0; b < 4; b++)
          if (e_gbe[b]) w[8*b +: 8] = e_gwd[8*b +: 8];
        ref_mem[int'(e_ga)] = w;
      end
      if (hit) m_prio = 1 - e_g;
      if (err_clear) begin
        m_ef = 0; m_ea = '0;
      end else if (hit && (!e_inr || (e_grd && e_gwr)) && !m_ef) begin
        m_ef = 1; m_ea = e_ga;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    cmd(0, 1, 0, 16'h0003, '0, 4'hF);
    cmd(1, 0, 1, 16'h0004, 32'h1, 4'hF);
    eval();
    total++; if (m0_if.waitrequest !== 1'b1) begin bad++;
      $display("FAIL rst_w0 got=%b exp=1", m0_if.waitrequest); end
    total++; if (m1_if.waitrequest !== 1'b1) begin bad++;
      $display("FAIL rst_w1 got=%b exp=1", m1_if.waitrequest); end
    total++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin
      bad++; $display("FAIL rst_valid got=%b%b exp=00",
        m0_if.readdatavalid, m1_if.readdatavalid); end
    total++; if ((m0_if.readdata | m1_if.readdata) !== 32'h0) begin bad++;
      $display("FAIL rst_rdata got=%h/%h exp=0",
        m0_if.readdata, m1_if.readdata); end
    total++; if ({mem_chipselect, mem_write, mem_clken} !== 3'b000) begin
      bad++; $display("FAIL rst_mem got=%b%b%b exp=000",
        mem_chipselect, mem_write, mem_clken); end
    total++; if ({err_flag, err_addr} !== 17'h0) begin bad++;
      $display("FAIL rst_err got=%b/%h exp=0/0", err_flag, err_addr); end
    advance();
    reset_n = 1;
    idle();
    eval();
    total++; if (mem_clken !== 1'b1) begin bad++;
      $display("FAIL run_clken got=%b exp=1", mem_clken); end
    total++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b00) begin
      bad++; $display("FAIL idle_wait got=%b%b exp=00",
        m0_if.waitrequest, m1_if.waitrequest); end
    advance();
  endtask

  task automatic test_contention();
    cmd(0, 1, 0, 16'h0040, '0, 4'hF);
    cmd(1, 1, 0, 16'h0041, '0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      eval();
      total++; if (m0_if.waitrequest !== (i % 2 == 1)) begin bad++;
        $display("FAIL cont_w0[%0d] got=%b", i, m0_if.waitrequest); end
      total++; if (m1_if.waitrequest !== (i % 2 == 0)) begin bad++;
        $display("FAIL cont_w1[%0d] got=%b", i, m1_if.waitrequest); end
      total++;
      if (m0_if.readdatavalid !== (i > 0 && (i - 1) % 2 == 0) ||
          m1_if.readdatavalid !== (i > 0 && (i - 1) % 2 == 1)) begin
        bad++; $display("FAIL cont_valid[%0d] got=%b%b", i,
          m0_if.readdatavalid, m1_if.readdatavalid); end
      if (e_v0) begin
        total++; if (m0_if.readdata !== e_d) begin bad++;
          $display("FAIL cont_rd0 got=%h exp=%h", m0_if.readdata, e_d); end
      end
      advance();
    end
    idle();
    eval();
    total++; if (m1_if.readdatavalid !== 1'b1 ||
                 m1_if.readdata !== ref_word(16'h0041)) begin bad++;
      $display("FAIL cont_last got=%b/%h exp=1/%h", m1_if.readdatavalid,
        m1_if.readdata, ref_word(16'h0041)); end
    advance();
  endtask

  task automatic test_single();
    cmd(0, 0, 1, 16'h0010, 32'h12345678, 4'hF);
    eval();
    total++; if ({m0_if.waitrequest, mem_chipselect, mem_write} !== 3'b011
                 || mem_address !== 16'h0010) begin bad++;
      $display("FAIL sgl_wr got=%b%b%b/%h exp=011/0010", m0_if.waitrequest,
        mem_chipselect, mem_write, mem_address); end
    advance();
    cmd(0, 1, 0, 16'h0010, '0, 4'hF);
    eval();
    total++; if ({m0_if.waitrequest, mem_chipselect, mem_write} !== 3'b010)
    begin bad++;
      $display("FAIL sgl_rd got=%b%b%b exp=010", m0_if.waitrequest,
        mem_chipselect, mem_write); end
    advance();
    idle();
    eval();
    total++; if (m0_if.readdatavalid !== 1'b1 ||
                 m0_if.readdata !== 32'h12345678) begin bad++;
      $display("FAIL sgl_data got=%b/%h exp=1/12345678",
        m0_if.readdatavalid, m0_if.readdata); end
    total++; if (m1_if.readdatavalid !== 1'b0) begin bad++;
      $display("FAIL sgl_m1v got=%b exp=0", m1_if.readdatavalid); end
    advance();
    eval();
    total++; if (m0_if.readdatavalid !== 1'b0) begin bad++;
      $display("FAIL sgl_once got=%b exp=0", m0_if.readdatavalid); end
    advance();
  endtask

  task automatic test_byte_lanes();
    cmd(1, 0, 1, 16'h0020, 32'hFFFFFFFF, 4'hF);
    eval(); advance();
    cmd(1, 0, 1, 16'h0020, 32'h000000AA, 4'h1);
    eval(); advance();
    cmd(1, 1, 0, 16'h0020, '0, 4'hF);
    eval(); advance();
    idle();
    eval();
    total++; if (m1_if.readdatavalid !== 1'b1 ||
                 m1_if.readdata !== 32'hFFFFFFAA) begin bad++;
      $display("FAIL be_data got=%b/%h exp=1/ffffffaa",
        m1_if.readdatavalid, m1_if.readdata); end
    advance();
  endtask

  task automatic test_out_of_range();
    err_clear = 1;
    eval(); advance();
    err_clear = 0;
    cmd(1, 0, 1, 16'hC800, 32'hDEADBEEF, 4'hF);
    eval();
    total++; if ({mem_chipselect, m1_if.waitrequest} !== 2'b00) begin
      bad++; $display("FAIL oor_wr got=%b%b exp=00",
        mem_chipselect, m1_if.waitrequest); end
    advance();
    cmd(1, 1, 0, 16'hC801, '0, 4'hF);
    eval();
    total++; if ({mem_chipselect, m1_if.waitrequest} !== 2'b00) begin
      bad++; $display("FAIL oor_rd got=%b%b exp=00",
        mem_chipselect, m1_if.waitrequest); end
    total++; if (err_flag !== 1'b1 || err_addr !== 16'hC800) begin bad++;
      $display("FAIL oor_err got=%b/%h exp=1/c800", err_flag, err_addr); end
    advance();
    idle();
    eval();
    total++; if (m1_if.readdatavalid !== 1'b1 ||
                 m1_if.readdata !== 32'h0) begin bad++;
      $display("FAIL oor_data got=%b/%h exp=1/0",
        m1_if.readdatavalid, m1_if.readdata); end
    total++; if (err_addr !== 16'hC800) begin bad++;
      $display("FAIL oor_keep got=%h exp=c800", err_addr); end
    advance();
    err_clear = 1;
    eval(); advance();
    err_clear = 0;
    eval();
    total++; if (err_flag !== 1'b0 || err_addr !== 16'h0) begin bad++;
      $display("FAIL oor_clr got=%b/%h exp=0/0", err_flag, err_addr); end
    advance();
  endtask

  task automatic test_protocol();
    cmd(0, 1, 1, 16'h0005, 32'hCAFEF00D, 4'hF);
    eval();
    total++; if ({m0_if.waitrequest, mem_chipselect, mem_write} !== 3'b011)
    begin bad++;
      $display("FAIL prot_wr got=%b%b%b exp=011", m0_if.waitrequest,
        mem_chipselect, mem_write); end
    advance();
    idle();
    eval();
    total++; if (m0_if.readdatavalid !== 1'b0) begin bad++;
      $display("FAIL prot_nov got=%b exp=0", m0_if.readdatavalid); end
    total++; if (err_flag !== 1'b1 || err_addr !== 16'h0005) begin bad++;
      $display("FAIL prot_err got=%b/%h exp=1/0005", err_flag, err_addr); end
    advance();
    cmd(0, 1, 0, 16'h0005, '0, 4'hF);
    eval(); advance();
    idle();
    eval();
    total++; if (m0_if.readdata !== 32'hCAFEF00D) begin bad++;
      $display("FAIL prot_data got=%h exp=cafef00d", m0_if.readdata); end
    advance();
  endtask

  task automatic test_reset_mid();
    cmd(1, 1, 0, 16'h0100, '0, 4'hF);
    eval();
    total++; if (m1_if.waitrequest !== 1'b0) begin bad++;
      $display("FAIL rmid_acc got=%b exp=0", m1_if.waitrequest); end
    advance();
    reset_n = 0;
    idle();
    eval();
    total++; if (m1_if.readdatavalid !== 1'b0) begin bad++;
      $display("FAIL rmid_in got=%b exp=0", m1_if.readdatavalid); end
    advance();
    reset_n = 1;
    eval();
    total++; if (m1_if.readdatavalid !== 1'b0) begin bad++;
      $display("FAIL rmid_out got=%b exp=0", m1_if.readdatavalid); end
    advance();
    cmd(0, 1, 0, 16'h0011, '0, 4'hF);
    cmd(1, 1, 0, 16'h0012, '0, 4'hF);
    eval();
    total++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin
      bad++; $display("FAIL rmid_prio got=%b%b exp=01",
        m0_if.waitrequest, m1_if.waitrequest); end
    advance();
    idle();
    eval(); advance();
  endtask

  task automatic test_random();
    bit st0 = 0, st1 = 0;
    int k;
    bit rd, wr;
    logic [15:0] a;
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!(m == 0 ? st0 : st1)) begin
          rd = 0; wr = 0;
          if ($urandom_range(0, 9) < 7) begin
            k = $urandom_range(0, 9);
            rd = (k < 5) || (k == 9);
            wr = (k >= 5);
          end
          a = ($urandom_range(0, 9) == 0) ?
            16'($urandom_range(51200, 65535)) : 16'($urandom_range(0, 63));
          cmd(m, rd, wr, a, $urandom, 4'($urandom));
        end
      end
      err_clear = ($urandom_range(0, 19) == 0);
      eval();
      total++; if (m0_if.waitrequest !== e_w0 ||
                   m1_if.waitrequest !== e_w1) begin bad++;
        $display("FAIL rnd_wait[%0d] got=%b%b exp=%b%b", n,
          m0_if.waitrequest, m1_if.waitrequest, e_w0, e_w1); end
      total++; if (m0_if.readdatavalid !== e_v0 ||
                   m1_if.readdatavalid !== e_v1) begin bad++;
        $display("FAIL rnd_valid[%0d] got=%b%b exp=%b%b", n,
          m0_if.readdatavalid, m1_if.readdatavalid, e_v0, e_v1); end
      total++; if (m0_if.readdata !== (e_v0 ? e_d : 32'h0) ||
                   m1_if.readdata !== (e_v1 ? e_d : 32'h0)) begin bad++;
        $display("FAIL rnd_rdata[%0d] got=%h/%h exp=%h", n,
          m0_if.readdata, m1_if.readdata, e_d); end
      total++; if (mem_chipselect !== e_cs || mem_write !== e_mw) begin
        bad++; $display("FAIL rnd_mem[%0d] got=%b%b exp=%b%b", n,
          mem_chipselect, mem_write, e_cs, e_mw); end
      if (e_cs) begin
        total++; if (mem_address !== e_ga) begin bad++;
          $display("FAIL rnd_addr[%0d] got=%h exp=%h", n,
            mem_address, e_ga); end
      end
      if (e_mw) begin
        total++; if (mem_writedata !== e_gwd ||
                     mem_byteenable !== e_gbe) begin bad++;
          $display("FAIL rnd_wdata[%0d] got=%h/%h exp=%h/%h", n,
            mem_writedata, mem_byteenable, e_gwd, e_gbe); end
      end
      total++; if (err_flag !== e_ef || err_addr !== e_ea) begin bad++;
        $display("FAIL rnd_err[%0d] got=%b/%h exp=%b/%h", n,
          err_flag, err_addr, e_ef, e_ea); end
      st0 = e_w0;
      st1 = e_w1;
      advance();
    end
    err_clear = 0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_contention();
    test_single();
    test_byte_lanes();
    test_out_of_range();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
